// File: rtl/spi_master_tx_if.sv
// spi_master_tx_if: host/SPI-link bundle for spi_master_tx.
// Host side: start, tx_data in; busy, done, rx_data out.
// SPI side: sclk, cs_n, mosi out; miso in.
// The master modport is the SPI master's view.
// The slave modport is the view of the host plus the remote SPI slave.
interface spi_master_tx_if #(
    parameter int DATASIZE = 128
);
    logic                start;
    logic [DATASIZE-1:0] tx_data;
    logic                busy;
    logic                done;
    logic [DATASIZE-1:0] rx_data;
    logic                sclk;
    logic                cs_n;
    logic                mosi;
    logic                miso;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, cs_n, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0 SPI master that sends one DATASIZE-bit word MSB first and captures miso.
// Ports:
//   clk, rst    system clock; asynchronous active-high reset
//   bus.start   request a transfer (sampled in IDLE only)
//   bus.tx_data word captured on the accepting edge
//   bus.busy    high from acceptance until done
//   bus.done    one-cycle end-of-transfer pulse
//   bus.rx_data captured word, updated with done
//   bus.sclk    SPI clock, idle low
//   bus.cs_n    chip select, active low
//   bus.mosi    serial out
//   bus.miso    serial in
// Optional receive path: define SPI_MASTER_RX_EN. Without it miso is ignored and rx_data stays 0.
module spi_master_tx #(
    parameter int DATASIZE = 128,
    parameter int CLK_DIV  = 4
) (
    input logic             clk,
    input logic             rst,
    spi_master_tx_if.master bus
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATASIZE + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [BW-1:0]       bits, bits_n;
    logic [DATASIZE-1:0] tx, tx_n, rx_data, rx_data_n;
    logic                sclk, sclk_n, cs_n, cs_n_n, mosi, mosi_n;
    logic                busy, busy_n, done, done_n;
    logic                tick;
`ifdef SPI_MASTER_RX_EN
    logic [DATASIZE-1:0] rx, rx_n;
`else
    logic                unused_miso;
    assign unused_miso = bus.miso;
`endif

    assign tick = cnt == CW'(CLK_DIV - 1);

    // The last sclk low phase doubles as the cs_n trailing gap, so once all
    // bits are sent HIGH goes straight to HOLD and the transfer ends one
    // half-period after the last falling edge.
    always_comb begin
        state_n   = state;
        cnt_n     = (state == IDLE || tick) ? '0 : cnt + 1'b1;
        bits_n    = bits;
        tx_n      = tx;
        rx_data_n = rx_data;
        sclk_n    = sclk;
        cs_n_n    = cs_n;
        mosi_n    = mosi;
        busy_n    = busy;
        done_n    = 1'b0;
`ifdef SPI_MASTER_RX_EN
        rx_n      = rx;
`endif
        if (state == IDLE && bus.start) begin
            state_n = SETUP;
            tx_n    = bus.tx_data;
            mosi_n  = bus.tx_data[DATASIZE-1];
            cs_n_n  = 1'b0;
            busy_n  = 1'b1;
            bits_n  = '0;
        end else if (tick && (state == SETUP || state == LOW)) begin
            state_n = HIGH;
            sclk_n  = 1'b1;
            bits_n  = bits + 1'b1;
`ifdef SPI_MASTER_RX_EN
            rx_n    = {rx[DATASIZE-2:0], bus.miso};
`endif
        end else if (tick && state == HIGH) begin
            state_n = bits == BW'(DATASIZE) ? HOLD : LOW;
            sclk_n  = 1'b0;
            if (bits != BW'(DATASIZE)) begin
                tx_n   = tx << 1;
                mosi_n = tx[DATASIZE-2];
            end
        end else if (tick && state == HOLD) begin
            state_n = IDLE;
            cs_n_n  = 1'b1;
            mosi_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
`ifdef SPI_MASTER_RX_EN
            rx_data_n = rx;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bits    <= '0;
            tx      <= '0;
            rx_data <= '0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SPI_MASTER_RX_EN
            rx      <= '0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bits    <= bits_n;
            tx      <= tx_n;
            rx_data <= rx_data_n;
            sclk    <= sclk_n;
            cs_n    <= cs_n_n;
            mosi    <= mosi_n;
            busy    <= busy_n;
            done    <= done_n;
`ifdef SPI_MASTER_RX_EN
            rx      <= rx_n;
`endif
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.rx_data = rx_data;
    assign bus.sclk    = sclk;
    assign bus.cs_n    = cs_n;
    assign bus.mosi    = mosi;
endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed bench for a default instance (loopback) and an 8-bit CLK_DIV=1 instance.
module tb_spi_master_tx;
`ifdef SPI_MASTER_RX_EN
    localparam bit RX = 1'b1;
`else
    localparam bit RX = 1'b0;
`endif
    localparam logic [127:0] T1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] T2 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] T3 = 128'h55aa55aa0f0f0f0ff0f0f0f0a5a5a5a5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_tx_if #(.DATASIZE(128)) i0();
    spi_master_tx_if #(.DATASIZE(8))   i1();

    spi_master_tx #(.DATASIZE(128), .CLK_DIV(4)) dut0 (.clk(clk), .rst(rst), .bus(i0));
    spi_master_tx #(.DATASIZE(8),   .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));

    int cyc = 0;
    int d0 = 0, d1 = 0, d0_at = 0, d1_at = 0, ovl = 0, r0 = 0, r1 = 0;
    int passed = 0, total = 0;
    int e0, e1, b, rb, first;
    logic [127:0] log0 = '0;
    logic [7:0]   log1 = '0;
    logic [7:0]   sw1 = 8'h3c;

    // loopback on the wide instance, shift-out slave model on the narrow one
    assign i0.miso = i0.mosi;
    assign i1.miso = (r1 < 8) ? sw1[3'(7 - r1)] : 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (i0.done) begin
            d0++;
            d0_at = cyc;
        end
        if (i1.done) begin
            d1++;
            d1_at = cyc;
        end
        if ((i0.done && i0.busy) || (i1.done && i1.busy)) ovl++;
    end

    always @(posedge i0.sclk) begin
        r0++;
        log0 = {log0[126:0], i0.mosi};
    end

    always @(posedge i1.sclk) begin
        r1++;
        log1 = {log1[6:0], i1.mosi};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_done0(input int n, input int lim, input string tag);
        int k = 0;
        while (d0 < n && k < lim) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, 128'(d0 >= n), 128'(1));
    endtask

    task automatic go0(input logic [127:0] w);
        @(negedge clk);
        i0.start   = 1'b1;
        i0.tx_data = w;
        @(posedge clk);
        #1;
        e0 = cyc;
        @(negedge clk);
        i0.start = 1'b0;
    endtask

    initial begin
        i0.start   = 1'b0;
        i0.tx_data = '0;
        i1.start   = 1'b0;
        i1.tx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_sclk",  128'(i0.sclk), 128'(0));
        chk("rst_cs_n",  128'(i0.cs_n), 128'(1));
        chk("rst_mosi",  128'(i0.mosi), 128'(0));
        chk("rst_busy",  128'(i0.busy), 128'(0));
        chk("rst_done",  128'(i0.done), 128'(0));
        chk("rst_rx",    i0.rx_data, '0);
        chk("rst_cs_n1", 128'(i1.cs_n), 128'(1));
        chk("rst_rx1",   128'(i1.rx_data), 128'(0));
        rst = 1'b0;
        // loopback with default parameters
        b  = d0;
        rb = r0;
        go0(T1);
        chk("accept_busy", 128'(i0.busy), 128'(1));
        chk("accept_cs_n", 128'(i0.cs_n), 128'(0));
        chk("accept_mosi", 128'(i0.mosi), 128'(1'b0));
        repeat (3) @(negedge clk);
        chk("lead_sclk_lo", 128'(i0.sclk), 128'(0));
        @(negedge clk);
        chk("lead_sclk_hi", 128'(i0.sclk), 128'(1));
        wait_done0(b + 1, 1100, "lb_done_seen");
        chk("lb_done_time", 128'(d0_at - e0), 128'(1028));
        chk("lb_rises",     128'(r0 - rb), 128'(128));
        chk("lb_mosi_word", log0, T1);
        chk("lb_rx_data",   i0.rx_data, RX ? T1 : '0);
        chk("lb_cs_n_end",  128'(i0.cs_n), 128'(1));
        @(negedge clk);
        chk("lb_done_pulse", 128'(i0.done), 128'(0));
        chk("lb_busy_end",   128'(i0.busy), 128'(0));
        // narrow instance, CLK_DIV=1
        @(negedge clk);
        i1.start   = 1'b1;
        i1.tx_data = 8'ha5;
        @(posedge clk);
        #1;
        e1 = cyc;
        @(negedge clk);
        i1.start = 1'b0;
        for (int k = 0; k < 40 && d1 == 0; k++) @(negedge clk);
        #1;
        chk("n_done_seen", 128'(d1), 128'(1));
        chk("n_done_time", 128'(d1_at - e1), 128'(17));
        chk("n_mosi_bits", 128'(log1), 128'(8'ha5));
        chk("n_rises",     128'(r1), 128'(8));
        chk("n_rx_data",   128'(i1.rx_data), 128'(RX ? 8'h3c : 8'h00));
        // start and tx_data changes while busy are ignored
        b = d0;
        go0(T2);
        while (cyc < e0 + 99) @(negedge clk);
        i0.start   = 1'b1;
        i0.tx_data = T3;
        @(negedge clk);
        i0.start = 1'b0;
        wait_done0(b + 1, 1100, "ig_done_seen");
        chk("ig_done_time", 128'(d0_at - e0), 128'(1028));
        repeat (20) @(negedge clk);
        chk("ig_single_done", 128'(d0 - b), 128'(1));
        chk("ig_mosi_word",   log0, T2);
        chk("ig_rx_data",     i0.rx_data, RX ? T2 : '0);
        // reset mid-transfer, right after the 63rd rise
        b = d0;
        go0(T1);
        while (cyc < e0 + 500) @(negedge clk);
        chk("ab_sclk_pre", 128'(i0.sclk), 128'(1));
        rst = 1'b1;
        #1;
        chk("ab_cs_n", 128'(i0.cs_n), 128'(1));
        chk("ab_sclk", 128'(i0.sclk), 128'(0));
        chk("ab_busy", 128'(i0.busy), 128'(0));
        chk("ab_mosi", 128'(i0.mosi), 128'(0));
        chk("ab_rx",   i0.rx_data, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (1100) @(negedge clk);
        chk("ab_no_done", 128'(d0 - b), 128'(0));
        b = d0;
        go0(T3);
        wait_done0(b + 1, 1100, "ab2_done_seen");
        chk("ab2_done_time", 128'(d0_at - e0), 128'(1028));
        chk("ab2_mosi_word", log0, T3);
        chk("ab2_rx_data",   i0.rx_data, RX ? T3 : '0);
        // start held high: back-to-back transfers
        b = d0;
        @(negedge clk);
        i0.start   = 1'b1;
        i0.tx_data = T1;
        @(posedge clk);
        #1;
        e0 = cyc;
        wait_done0(b + 1, 1100, "bb_done1_seen");
        first = d0_at;
        chk("bb_done1_time", 128'(first - e0), 128'(1028));
        chk("bb_gap_cs_n",   128'(i0.cs_n), 128'(1));
        @(negedge clk);
        chk("bb_restart_cs_n", 128'(i0.cs_n), 128'(0));
        chk("bb_restart_busy", 128'(i0.busy), 128'(1));
        wait_done0(b + 2, 1100, "bb_done2_seen");
        i0.start = 1'b0;
        chk("bb_done_spacing", 128'(d0_at - first), 128'(1029));
        @(negedge clk);
        #1;
        chk("bb_idle_busy", 128'(i0.busy), 128'(0));
        chk("bb_idle_cs_n", 128'(i0.cs_n), 128'(1));
        chk("no_overlap",   128'(ovl), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
